// File: rtl/wb_stage_if.sv
// MEM -> W pipeline bundle: inputs from the memory stage and the
// register-file write port that the decode stage consumes.
interface wb_stage_if;
    logic [31:0] instr_m;
    logic [31:0] pc_m;
    logic [31:0] alu_data_m;
    logic [31:0] ld_data_m;
    logic        rd_wren_m;
    logic [1:0]  wb_sel_m;
    logic        insn_vld_m;

    logic [31:0] instr_w;
    logic        rd_wren_w;
    logic [31:0] wb_data_w;
    logic        insn_vld_w;

    // Pipeline side: drives the MEM fields, observes the write port
    modport master (
        output instr_m, pc_m, alu_data_m, ld_data_m, rd_wren_m, wb_sel_m, insn_vld_m,
        input  instr_w, rd_wren_w, wb_data_w, insn_vld_w
    );

    // Writeback stage side
    modport slave (
        input  instr_m, pc_m, alu_data_m, ld_data_m, rd_wren_m, wb_sel_m, insn_vld_m,
        output instr_w, rd_wren_w, wb_data_w, insn_vld_w
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage of the non-forwarding RV32I pipeline: MEM/WB register,
// load-data extraction, writeback source mux and retired-instruction counter.
module wb_stage #(
    parameter int          CNT_W    = 64,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic             i_clk,
    input  logic             i_rst,
    wb_stage_if.slave        wb,
    input  logic             i_stall,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_instret
);

    logic [31:0]      instr_w_r;
    logic [31:0]      pc_w_r;
    logic [31:0]      alu_data_w_r;
    logic [31:0]      ld_data_w_r;
    logic [1:0]       wb_sel_w_r;
    logic             rd_wren_w_r;
    logic             insn_vld_w_r;
    logic [CNT_W-1:0] instret_r;

    logic             retire_s;
    logic [31:0]      load_s;
    logic [31:0]      wb_data_s;

    // Byte/halfword select and extension of the aligned load word (little-endian)
    function automatic logic [31:0] load_extract(
        input logic [2:0]  funct3,
        input logic [1:0]  addr_lo,
        input logic [31:0] word
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = 8'(word >> {addr_lo, 3'b000});
        half_v = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  load_extract = {{24{byte_v[7]}}, byte_v};
            3'b100:  load_extract = {24'h00_0000, byte_v};
            3'b001:  load_extract = {{16{half_v[15]}}, half_v};
            3'b101:  load_extract = {16'h0000, half_v};
            3'b010:  load_extract = word;
            default: load_extract = 32'h0000_0000;
        endcase
    endfunction

    // The W instruction leaves the stage on any non-stalled edge; a flush still retires it
    assign retire_s = insn_vld_w_r & (~i_stall | i_flush);

    // MEM/WB register with flush-over-stall priority, plus retire counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            instr_w_r    <= NOP_INSN;
            pc_w_r       <= 32'h0000_0000;
            alu_data_w_r <= 32'h0000_0000;
            ld_data_w_r  <= 32'h0000_0000;
            wb_sel_w_r   <= 2'b00;
            rd_wren_w_r  <= 1'b0;
            insn_vld_w_r <= 1'b0;
            instret_r    <= '0;
        end else begin
            if (i_flush) begin
                instr_w_r    <= NOP_INSN;
                pc_w_r       <= 32'h0000_0000;
                alu_data_w_r <= 32'h0000_0000;
                ld_data_w_r  <= 32'h0000_0000;
                wb_sel_w_r   <= 2'b00;
                rd_wren_w_r  <= 1'b0;
                insn_vld_w_r <= 1'b0;
            end else if (i_stall) begin
                instr_w_r    <= instr_w_r;
                pc_w_r       <= pc_w_r;
                alu_data_w_r <= alu_data_w_r;
                ld_data_w_r  <= ld_data_w_r;
                wb_sel_w_r   <= wb_sel_w_r;
                rd_wren_w_r  <= rd_wren_w_r;
                insn_vld_w_r <= insn_vld_w_r;
            end else begin
                instr_w_r    <= wb.instr_m;
                pc_w_r       <= wb.pc_m;
                alu_data_w_r <= wb.alu_data_m;
                ld_data_w_r  <= wb.ld_data_m;
                wb_sel_w_r   <= wb.wb_sel_m;
                rd_wren_w_r  <= wb.rd_wren_m;
                insn_vld_w_r <= wb.insn_vld_m;
            end
            if (retire_s) begin
                instret_r <= instret_r + CNT_W'(1);
            end else begin
                instret_r <= instret_r;
            end
        end
    end

    assign load_s = load_extract(instr_w_r[14:12], alu_data_w_r[1:0], ld_data_w_r);

    // Writeback source select; reserved encoding writes zero
    always_comb begin
        wb_data_s = 32'h0000_0000;
        case (wb_sel_w_r)
            2'b00:   wb_data_s = alu_data_w_r;
            2'b01:   wb_data_s = load_s;
            2'b10:   wb_data_s = pc_w_r + 32'd4;
            default: wb_data_s = 32'h0000_0000;
        endcase
    end

    assign wb.instr_w    = instr_w_r;
    assign wb.insn_vld_w = insn_vld_w_r;
    assign wb.wb_data_w  = wb_data_s;
    // x0 is hardwired, so never request a write to it
    assign wb.rd_wren_w  = rd_wren_w_r & insn_vld_w_r & (instr_w_r[11:7] != 5'd0);
    assign o_instret     = instret_r;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a 64-bit counter instance and a 4-bit
// counter instance driven by the same MEM-side stimulus.
module tb_wb_stage;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        wren;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic [31:0] m_alu;
    logic [31:0] m_ld;
    logic        m_wren;
    logic [1:0]  m_sel;
    logic        m_vld;

    logic [63:0] instret;
    logic [3:0]  instret4;

    exp_t        sb[$];
    logic [63:0] model_cnt;
    logic        model_vld;
    int          n_tests;
    int          n_fail;

    wb_stage_if wbi ();
    wb_stage_if wbi4 ();

    assign wbi.instr_m     = m_instr;
    assign wbi.pc_m        = m_pc;
    assign wbi.alu_data_m  = m_alu;
    assign wbi.ld_data_m   = m_ld;
    assign wbi.rd_wren_m   = m_wren;
    assign wbi.wb_sel_m    = m_sel;
    assign wbi.insn_vld_m  = m_vld;
    assign wbi4.instr_m    = m_instr;
    assign wbi4.pc_m       = m_pc;
    assign wbi4.alu_data_m = m_alu;
    assign wbi4.ld_data_m  = m_ld;
    assign wbi4.rd_wren_m  = m_wren;
    assign wbi4.wb_sel_m   = m_sel;
    assign wbi4.insn_vld_m = m_vld;

    wb_stage #(.CNT_W(64), .NOP_INSN(32'h0000_0013)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .wb        (wbi),
        .i_stall   (stall),
        .i_flush   (flush),
        .o_instret (instret)
    );

    wb_stage #(.CNT_W(4), .NOP_INSN(32'h0000_0013)) dut4 (
        .i_clk     (clk),
        .i_rst     (rst),
        .wb        (wbi4),
        .i_stall   (stall),
        .i_flush   (flush),
        .o_instret (instret4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ld_insn(input logic [2:0] f3, input logic [4:0] rd);
        ld_insn = {12'h000, 5'd2, f3, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] jal_insn(input logic [4:0] rd);
        jal_insn = {20'h00000, rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] add_insn(input logic [4:0] rd);
        add_insn = {7'h00, 5'd2, 5'd1, 3'b000, rd, 7'b0110011};
    endfunction

    // One clock: update the retire model at the edge, then compare outputs
    task automatic tick();
        exp_t e;
        @(posedge clk);
        if (rst) begin
            model_cnt = 64'd0;
            model_vld = 1'b0;
        end else if (flush) begin
            model_cnt = model_cnt + 64'(model_vld);
            model_vld = 1'b0;
        end else if (!stall) begin
            model_cnt = model_cnt + 64'(model_vld);
            model_vld = m_vld;
        end
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".data"}, 64'(wbi.wb_data_w), 64'(e.data));
            check({e.tag, ".wren"}, 64'(wbi.rd_wren_w), 64'(e.wren));
        end
        check("instret", instret, model_cnt);
        check("instret4", 64'(instret4), 64'(model_cnt[3:0]));
    endtask

    task automatic drive(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] ld, input logic wren,
                         input logic [1:0] sel, input logic vld,
                         input logic [31:0] exp_data, input logic exp_wren);
        exp_t e;
        m_instr = ins;
        m_pc    = pc;
        m_alu   = alu;
        m_ld    = ld;
        m_wren  = wren;
        m_sel   = sel;
        m_vld   = vld;
        if (vld && !stall && !flush && !rst) begin
            e.tag  = tag;
            e.data = exp_data;
            e.wren = exp_wren;
            sb.push_back(e);
        end
        tick();
    endtask

    task automatic idle();
        drive("idle", 32'h0000_0013, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
    endtask

    localparam logic [31:0] LD_WORD = 32'h80FF_7F01;

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        stall     = 1'b0;
        flush     = 1'b0;
        m_instr   = 32'h0000_0013;
        m_pc      = 32'h0;
        m_alu     = 32'h0;
        m_ld      = 32'h0;
        m_wren    = 1'b0;
        m_sel     = 2'b00;
        m_vld     = 1'b0;
        model_cnt = 64'd0;
        model_vld = 1'b0;
        n_tests   = 0;
        n_fail    = 0;

        #1;
        check("rst.instr", 64'(wbi.instr_w), 64'h13);
        check("rst.wren", 64'(wbi.rd_wren_w), 64'h0);
        check("rst.data", 64'(wbi.wb_data_w), 64'h0);
        check("rst.instret", instret, 64'h0);
        idle();
        #2 rst = 1'b0;

        // Loads from the same memory word
        drive("lb_a1", ld_insn(3'b000, 5'd3), 32'h40, 32'h1001, LD_WORD, 1'b1, 2'b01, 1'b1, 32'h0000_007F, 1'b1);
        drive("lb_a2", ld_insn(3'b000, 5'd3), 32'h44, 32'h1002, LD_WORD, 1'b1, 2'b01, 1'b1, 32'hFFFF_FFFF, 1'b1);
        drive("lbu_a3", ld_insn(3'b100, 5'd4), 32'h48, 32'h1003, LD_WORD, 1'b1, 2'b01, 1'b1, 32'h0000_0080, 1'b1);
        drive("lh_a2", ld_insn(3'b001, 5'd5), 32'h4C, 32'h1002, LD_WORD, 1'b1, 2'b01, 1'b1, 32'hFFFF_80FF, 1'b1);
        drive("lhu_a0", ld_insn(3'b101, 5'd6), 32'h50, 32'h1000, LD_WORD, 1'b1, 2'b01, 1'b1, 32'h0000_7F01, 1'b1);
        drive("lw", ld_insn(3'b010, 5'd7), 32'h54, 32'h1000, LD_WORD, 1'b1, 2'b01, 1'b1, 32'h80FF_7F01, 1'b1);
        drive("lh_a1", ld_insn(3'b001, 5'd8), 32'h58, 32'h1001, LD_WORD, 1'b1, 2'b01, 1'b1, 32'h0000_7F01, 1'b1);
        drive("ld_f3bad", ld_insn(3'b011, 5'd9), 32'h5C, 32'h1000, LD_WORD, 1'b1, 2'b01, 1'b1, 32'h0, 1'b1);
        drive("lw_x0", ld_insn(3'b010, 5'd0), 32'h60, 32'h1000, LD_WORD, 1'b1, 2'b01, 1'b1, 32'h80FF_7F01, 1'b0);

        // PC+4 source, x0 suppression, wrap, reserved select
        drive("jal_x1", jal_insn(5'd1), 32'h0000_0100, 32'h0, 32'h0, 1'b1, 2'b10, 1'b1, 32'h0000_0104, 1'b1);
        drive("jal_x0", jal_insn(5'd0), 32'h0000_0100, 32'h0, 32'h0, 1'b1, 2'b10, 1'b1, 32'h0000_0104, 1'b0);
        drive("jal_wrap", jal_insn(5'd1), 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 2'b10, 1'b1, 32'h0, 1'b1);
        drive("sel_rsvd", add_insn(5'd2), 32'h64, 32'hABCD, 32'h0, 1'b1, 2'b11, 1'b1, 32'h0, 1'b1);
        drive("nowren", add_insn(5'd2), 32'h68, 32'h5555, 32'h0, 1'b0, 2'b00, 1'b1, 32'h5555, 1'b0);

        // Stall holds W for three cycles, then retires once
        drive("add_x5", add_insn(5'd5), 32'h6C, 32'h1234, 32'h0, 1'b1, 2'b00, 1'b1, 32'h1234, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive("stalled", add_insn(5'd6), 32'h70, 32'h9999, 32'h0, 1'b1, 2'b00, 1'b1, 32'h0, 1'b0);
            check("stall.data", 64'(wbi.wb_data_w), 64'h1234);
            check("stall.wren", 64'(wbi.rd_wren_w), 64'h1);
        end
        stall = 1'b0;
        idle();

        // Flush with stall: bubble loaded, W instruction still retires
        drive("add_x7", add_insn(5'd7), 32'h74, 32'h4321, 32'h0, 1'b1, 2'b00, 1'b1, 32'h4321, 1'b1);
        stall = 1'b1;
        flush = 1'b1;
        drive("flushed", add_insn(5'd8), 32'h78, 32'h7777, 32'h0, 1'b1, 2'b00, 1'b1, 32'h0, 1'b0);
        check("flush.instr", 64'(wbi.instr_w), 64'h13);
        check("flush.vld", 64'(wbi.insn_vld_w), 64'h0);
        check("flush.wren", 64'(wbi.rd_wren_w), 64'h0);
        stall = 1'b0;
        flush = 1'b0;
        idle();

        // Asynchronous reset with a valid load sitting in W
        drive("lw_pre", ld_insn(3'b010, 5'd9), 32'h7C, 32'h1000, LD_WORD, 1'b1, 2'b01, 1'b1, 32'h80FF_7F01, 1'b1);
        #2 rst = 1'b1;
        model_cnt = 64'd0;
        model_vld = 1'b0;
        #1;
        check("arst.instr", 64'(wbi.instr_w), 64'h13);
        check("arst.wren", 64'(wbi.rd_wren_w), 64'h0);
        check("arst.data", 64'(wbi.wb_data_w), 64'h0);
        check("arst.instret", instret, 64'h0);
        idle();
        #2 rst = 1'b0;

        // 17 retirements wrap the 4-bit counter to 1
        for (int i = 0; i < 17; i++) begin
            drive("wrap_add", add_insn(5'd3), 32'h200 + 32'(i * 4), 32'(i + 16), 32'h0, 1'b1, 2'b00, 1'b1, 32'(i + 16), 1'b1);
        end
        idle();
        check("wrap.instret4", 64'(instret4), 64'h1);
        check("wrap.instret", instret, 64'd17);
        idle();
        check("wrap.hold4", 64'(instret4), 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
